// File: rtl/stoch_signed_addsub_mat.sv
// Element-wise signed stochastic matrix adder/subtractor.
// Each element combines two bipolar bitstream pairs (plus/minus rails) and
// re-emits the net value as a single registered plus/minus pulse pair.
// The unit that cannot be emitted on a given cycle is carried in a saturating
// signed residue counter. Vector ports are packed column-major:
// element (i,j) sits at bit j*NUM_ROWS+i.
module stoch_signed_addsub_mat #(
   parameter int NUM_ROWS  = 2,
   parameter int NUM_COLS  = 2,
   parameter int CNT_WIDTH = 4
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         EN,
   input  logic [NUM_ROWS*NUM_COLS-1:0] MODE,
   input  logic [NUM_ROWS*NUM_COLS-1:0] A_p,
   input  logic [NUM_ROWS*NUM_COLS-1:0] A_m,
   input  logic [NUM_ROWS*NUM_COLS-1:0] B_p,
   input  logic [NUM_ROWS*NUM_COLS-1:0] B_m,
   output logic [NUM_ROWS*NUM_COLS-1:0] Y_p,
   output logic [NUM_ROWS*NUM_COLS-1:0] Y_m,
   output logic [NUM_ROWS*NUM_COLS-1:0] SAT
);

   localparam int NE = NUM_ROWS * NUM_COLS;
   // Two guard bits hold counter + net (net spans -2..+2) without overflow.
   localparam int TW = CNT_WIDTH + 2;

   localparam logic signed [TW-1:0] ZERO_T = '0;
   localparam logic signed [TW-1:0] ONE_T  = TW'(1);
   // Symmetric range: the most negative code is never stored.
   localparam logic signed [TW-1:0] CMAX_T = TW'((2 ** (CNT_WIDTH - 1)) - 1);
   localparam logic signed [TW-1:0] CMIN_T = -CMAX_T;

   // One unit of the total leaves as an output pulse; the rest is residue.
   function automatic logic signed [TW-1:0] residue_after_emit(
      input logic signed [TW-1:0] t
   );
      logic signed [TW-1:0] r;
      if (t > ZERO_T) begin
         r = t - ONE_T;
      end else if (t < ZERO_T) begin
         r = t + ONE_T;
      end else begin
         r = ZERO_T;
      end
      return r;
   endfunction

   // Clip the residue into the symmetric counter range.
   function automatic logic signed [CNT_WIDTH-1:0] sat_clip(
      input logic signed [TW-1:0] v
   );
      logic signed [TW-1:0] r;
      if (v > CMAX_T) begin
         r = CMAX_T;
      end else if (v < CMIN_T) begin
         r = CMIN_T;
      end else begin
         r = v;
      end
      return r[CNT_WIDTH-1:0];
   endfunction

   // True when the residue falls outside the representable range.
   function automatic logic sat_hit(input logic signed [TW-1:0] v);
      return (v > CMAX_T) || (v < CMIN_T);
   endfunction

   for (genvar e = 0; e < NE; e++) begin : g_elem
      logic signed [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                        y_p_q, y_p_d;
      logic                        y_m_q, y_m_d;
      logic                        sat_q, sat_d;
      logic signed [TW-1:0]        pos, neg, tot, rem;

      // Combine operand rails, emit one pulse toward the sign of the total and keep the residue.
      always_comb begin
         cnt_d = cnt_q;
         sat_d = sat_q;
         y_p_d = 1'b0;
         y_m_d = 1'b0;
         // Subtraction swaps B's rails, so the same net/emit path serves both modes.
         pos   = TW'(A_p[e]) + TW'(MODE[e] ? B_m[e] : B_p[e]);
         neg   = TW'(A_m[e]) + TW'(MODE[e] ? B_p[e] : B_m[e]);
         tot   = {{(TW - CNT_WIDTH){cnt_q[CNT_WIDTH-1]}}, cnt_q} + pos - neg;
         rem   = residue_after_emit(tot);
         if (EN) begin
            y_p_d = (tot > ZERO_T);
            y_m_d = (tot < ZERO_T);
            cnt_d = sat_clip(rem);
            sat_d = sat_q | sat_hit(rem);
         end
      end

      // Element state; reset wins over enable and discards any residue.
      always_ff @(posedge CLK) begin
         if (RST) begin
            cnt_q <= '0;
            y_p_q <= 1'b0;
            y_m_q <= 1'b0;
            sat_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            y_p_q <= y_p_d;
            y_m_q <= y_m_d;
            sat_q <= sat_d;
         end
      end

      assign Y_p[e] = y_p_q;
      assign Y_m[e] = y_m_q;
      assign SAT[e] = sat_q;
   end

endmodule

// File: tb/tb_stoch_signed_addsub_mat.sv
// Bench for stoch_signed_addsub_mat: a 2x2 instance with 4-bit counters and a
// 2x2 instance with 3-bit counters share the same stimulus. Directed scenarios
// use hand-derived expectations; the random scenario compares against an
// integer per-element reference model.
module tb_stoch_signed_addsub_mat;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       RST = 1'b1;
   logic       EN  = 1'b1;
   logic [3:0] MODE = '0, A_p = '0, A_m = '0, B_p = '0, B_m = '0;
   logic [3:0] y4_p, y4_m, sat4;
   logic [3:0] y3_p, y3_m, sat3;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int         c4[4];
   int         c3[4];
   logic [3:0] ey4p = '0, ey4m = '0, es4 = '0;
   logic [3:0] ey3p = '0, ey3m = '0, es3 = '0;

   stoch_signed_addsub_mat #(.NUM_ROWS(2), .NUM_COLS(2), .CNT_WIDTH(4)) dut4 (
      .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE),
      .A_p(A_p), .A_m(A_m), .B_p(B_p), .B_m(B_m),
      .Y_p(y4_p), .Y_m(y4_m), .SAT(sat4)
   );

   stoch_signed_addsub_mat #(.NUM_ROWS(2), .NUM_COLS(2), .CNT_WIDTH(3)) dut3 (
      .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE),
      .A_p(A_p), .A_m(A_m), .B_p(B_p), .B_m(B_m),
      .Y_p(y3_p), .Y_m(y3_m), .SAT(sat3)
   );

   // One enabled cycle of one element, in plain integer arithmetic.
   function automatic void elem(input int w, inout int c, inout logic s,
                                output logic yp, output logic ym,
                                input logic m, input logic ap, input logic am,
                                input logic bp, input logic bm);
      int cmax, a_val, b_val, t;
      cmax  = (1 << (w - 1)) - 1;
      a_val = int'(ap) - int'(am);
      b_val = int'(bp) - int'(bm);
      t     = c + (m ? a_val - b_val : a_val + b_val);
      yp    = (t > 0);
      ym    = (t < 0);
      if (t > 0)      t = t - 1;
      else if (t < 0) t = t + 1;
      if (t > cmax) begin
         t = cmax;  s = 1'b1;
      end else if (t < -cmax) begin
         t = -cmax; s = 1'b1;
      end
      c = t;
   endfunction

   // Advance one clock: update the model from the sampled inputs, then settle.
   task automatic tick();
      int   c;
      logic s, yp, ym;
      @(posedge CLK);
      for (int e = 0; e < 4; e++) begin
         if (RST) begin
            c4[e] = 0; c3[e] = 0;
            es4[e] = 1'b0; es3[e] = 1'b0;
            ey4p[e] = 1'b0; ey4m[e] = 1'b0; ey3p[e] = 1'b0; ey3m[e] = 1'b0;
         end else if (!EN) begin
            ey4p[e] = 1'b0; ey4m[e] = 1'b0; ey3p[e] = 1'b0; ey3m[e] = 1'b0;
         end else begin
            c = c4[e]; s = es4[e];
            elem(4, c, s, yp, ym, MODE[e], A_p[e], A_m[e], B_p[e], B_m[e]);
            c4[e] = c; es4[e] = s; ey4p[e] = yp; ey4m[e] = ym;
            c = c3[e]; s = es3[e];
            elem(3, c, s, yp, ym, MODE[e], A_p[e], A_m[e], B_p[e], B_m[e]);
            c3[e] = c; es3[e] = s; ey3p[e] = yp; ey3m[e] = ym;
         end
      end
      #1;
   endtask

   task automatic clear_inputs();
      MODE = '0; A_p = '0; A_m = '0; B_p = '0; B_m = '0; EN = 1'b1;
   endtask

   task automatic do_reset();
      clear_inputs();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; EN = 1'b1;
      MODE = '1; A_p = '1; A_m = '1; B_p = '1; B_m = '1;
      tick(); tick();
      checks++;
      if ({y4_p, y4_m, sat4, y3_p, y3_m, sat3} !== 24'h0) begin
         failures++;
         $display("FAIL reset_state got y4p=%b y4m=%b sat4=%b y3p=%b y3m=%b sat3=%b want all 0",
                  y4_p, y4_m, sat4, y3_p, y3_m, sat3);
      end
      RST = 1'b0;
      clear_inputs();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({y4_p, y4_m, sat4, y3_p, y3_m, sat3} !== 24'h0) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got y4p=%b y4m=%b sat4=%b y3p=%b y3m=%b sat3=%b want all 0",
                     k, y4_p, y4_m, sat4, y3_p, y3_m, sat3);
         end
      end
   endtask

   task automatic test_accumulate();
      int         total;
      logic [3:0] want_p;
      do_reset();
      total = 0;
      for (int k = 1; k <= 12; k++) begin
         A_p[0] = (k <= 4); B_p[0] = (k <= 4);
         tick();
         want_p = (k <= 8) ? 4'b0001 : 4'b0000;
         total += int'(y4_p[0]);
         checks++;
         if ({y4_p, y4_m, sat4} !== {want_p, 8'h00}) begin
            failures++;
            $display("FAIL accumulate cyc=%0d got p=%b m=%b sat=%b want p=%b m=0000 sat=0000",
                     k, y4_p, y4_m, sat4, want_p);
         end
      end
      checks++;
      if (total != 8) begin
         failures++;
         $display("FAIL accumulate_count got %0d want 8", total);
      end
   endtask

   task automatic test_mode_switch();
      do_reset();
      MODE[3] = 1'b1; A_p[3] = 1'b1; B_p[3] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if ({y4_p, y4_m, sat4} !== 12'h000) begin
            failures++;
            $display("FAIL mode_sub_cancel cyc=%0d got p=%b m=%b sat=%b want all 0",
                     k, y4_p, y4_m, sat4);
         end
      end
      MODE[3] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if ({y4_p, y4_m, sat4} !== {4'b1000, 8'h00}) begin
            failures++;
            $display("FAIL mode_add cyc=%0d got p=%b m=%b sat=%b want p=1000 m=0000 sat=0000",
                     k, y4_p, y4_m, sat4);
         end
      end
   endtask

   task automatic test_saturation();
      logic want_m, want_s;
      do_reset();
      MODE[1] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         A_m[1] = (k <= 6); B_p[1] = (k <= 6);
         tick();
         want_m = (k <= 9);
         want_s = (k >= 4);
         checks++;
         if ({y3_p, y3_m, sat3} !== {4'b0000, 2'b00, want_m, 1'b0, 2'b00, want_s, 1'b0}) begin
            failures++;
            $display("FAIL saturation cyc=%0d got p=%b m=%b sat=%b want p=0000 m=00%b0 sat=00%b0",
                     k, y3_p, y3_m, sat3, want_m, want_s);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      A_p[0] = 1'b1; B_p[0] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({y4_p, y4_m} !== {4'b0001, 4'b0000}) begin
            failures++;
            $display("FAIL stall_load cyc=%0d got p=%b m=%b want p=0001 m=0000", k, y4_p, y4_m);
         end
      end
      EN = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if ({y4_p, y4_m, sat4} !== 12'h000) begin
            failures++;
            $display("FAIL stall_quiet cyc=%0d got p=%b m=%b sat=%b want all 0", k, y4_p, y4_m, sat4);
         end
      end
      EN = 1'b1; A_p[0] = 1'b0; B_p[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({y4_p, y4_m} !== {((k < 2) ? 4'b0001 : 4'b0000), 4'b0000}) begin
            failures++;
            $display("FAIL stall_drain cyc=%0d got p=%b m=%b want p=%b m=0000",
                     k, y4_p, y4_m, (k < 2) ? 4'b0001 : 4'b0000);
         end
      end
   endtask

   task automatic test_midstream_reset();
      do_reset();
      A_p[0] = 1'b1; B_p[0] = 1'b1;
      tick(); tick(); tick();
      B_p[0] = 1'b0;
      RST = 1'b1;
      tick();
      checks++;
      if ({y4_p, y4_m, sat4, y3_p, y3_m, sat3} !== 24'h0) begin
         failures++;
         $display("FAIL midreset_out got y4p=%b y4m=%b sat4=%b y3p=%b y3m=%b sat3=%b want all 0",
                  y4_p, y4_m, sat4, y3_p, y3_m, sat3);
      end
      RST = 1'b0;
      clear_inputs();
      tick();
      checks++;
      if ({y4_p, y4_m, y3_p, y3_m} !== 16'h0) begin
         failures++;
         $display("FAIL midreset_residue got y4p=%b y4m=%b y3p=%b y3m=%b want all 0",
                  y4_p, y4_m, y3_p, y3_m);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 10000; k++) begin
         MODE = 4'($urandom); A_p = 4'($urandom); A_m = 4'($urandom);
         B_p  = 4'($urandom); B_m = 4'($urandom);
         EN   = ($urandom_range(0, 7) != 0);
         RST  = ($urandom_range(0, 499) == 0);
         tick();
         checks++;
         if ({y4_p, y4_m, sat4} !== {ey4p, ey4m, es4}) begin
            failures++;
            $display("FAIL random_w4 cyc=%0d got p=%b m=%b sat=%b want p=%b m=%b sat=%b",
                     k, y4_p, y4_m, sat4, ey4p, ey4m, es4);
         end
         checks++;
         if ({y3_p, y3_m, sat3} !== {ey3p, ey3m, es3}) begin
            failures++;
            $display("FAIL random_w3 cyc=%0d got p=%b m=%b sat=%b want p=%b m=%b sat=%b",
                     k, y3_p, y3_m, sat3, ey3p, ey3m, es3);
         end
      end
      RST = 1'b0;
   endtask

   initial begin
      for (int e = 0; e < 4; e++) begin
         c4[e] = 0; c3[e] = 0;
      end
      test_reset();
      test_accumulate();
      test_mode_switch();
      test_saturation();
      test_stall();
      test_midstream_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
